// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// fifo_stream_reader : turns a 1-cycle-latency FIFO read port into a
// valid/ready stream through a 2-entry buffer (full rate, no bubbles).
// Revision: 1.0
// ============================================================================
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            occ,
   output logic [CNT_WIDTH-1:0]  xfer_count
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
   logic                  hd_q;
   logic                  hd_d;
   logic [1:0]            occ_q;
   logic [1:0]            occ_d;
   logic                  inflight_q;
   logic                  inflight_d;
   logic [CNT_WIDTH-1:0]  xfer_count_q;
   logic [CNT_WIDTH-1:0]  xfer_count_d;

   logic                  pop;
   logic [2:0]            demand;
   logic                  slot;

   always_comb begin
      mem_d        = mem_q;
      hd_d         = hd_q;
      occ_d        = occ_q;
      inflight_d   = inflight_q;
      xfer_count_d = xfer_count_q;
      pop          = 1'b0;
      demand       = 3'd0;
      slot         = 1'b0;
      fifo_rd_en   = 1'b0;

      pop = (occ_q != 2'd0) & m_ready;

      // Words owned after this edge; a pop only happens with occ>=1, so no underflow.
      demand = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

      // rst gates the strobe so the FIFO is never read while both blocks are held in reset.
      fifo_rd_en = ~rst & ~fifo_empty & (demand < 3'd2);

      // Capture slot from pre-pop state; occ<=1 whenever a word is in flight.
      slot = hd_q ^ occ_q[0];
      if (inflight_q) begin
         mem_d[slot] = fifo_rd_data;
      end

      occ_d        = demand[1:0];
      hd_d         = hd_q ^ pop;
      inflight_d   = fifo_rd_en;
      xfer_count_d = xfer_count_q + CNT_WIDTH'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0]     <= '0;
         mem_q[1]     <= '0;
         hd_q         <= 1'b0;
         occ_q        <= 2'd0;
         inflight_q   <= 1'b0;
         xfer_count_q <= '0;
      end else begin
         mem_q[0]     <= mem_d[0];
         mem_q[1]     <= mem_d[1];
         hd_q         <= hd_d;
         occ_q        <= occ_d;
         inflight_q   <= inflight_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   assign m_valid    = (occ_q != 2'd0);
   assign m_data     = mem_q[hd_q];
   assign occ        = occ_q;
   assign xfer_count = xfer_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// tb_fifo_stream_reader : bench with a queue-based FIFO and a stream-order model.
// Revision: 1.0
// ============================================================================
module tb_fifo_stream_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty = 1'b1;
   logic       fifo_rd_en;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic [1:0] occ;
   logic [15:0] xfer_count;

   logic       rd_en4;
   logic       valid4;
   logic [7:0] data4;
   logic [1:0] occ4;
   logic [3:0] xfer4;

   int checks = 0;
   int errors = 0;

   fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .occ(occ), .xfer_count(xfer_count)
   );

   fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en4),
      .fifo_rd_data(fifo_rd_data), .m_valid(valid4), .m_ready(m_ready),
      .m_data(data4), .occ(occ4), .xfer_count(xfer4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural synchronous FIFO: writes land at the edge, reads return data one cycle later.
   logic [7:0] fmem[$];
   logic [7:0] wr_pend[$];
   logic [7:0] exp_out[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fmem.delete();
         wr_pend.delete();
         fifo_empty   <= 1'b1;
         fifo_rd_data <= 8'h00;
      end else begin
         if (fifo_rd_en && fmem.size() > 0) fifo_rd_data <= fmem.pop_front();
         while (wr_pend.size() > 0) fmem.push_back(wr_pend.pop_front());
         fifo_empty <= (fmem.size() == 0);
      end
   end

   task automatic wr(input logic [7:0] w);
      wr_pend.push_back(w);
      exp_out.push_back(w);
   endtask

   // Stream model: words leave in write order; occupancy = words arrived minus words taken.
   int          m_occ = 0;
   int          m_infl = 0;
   int          pop_i;
   int          exp_rd;
   int unsigned m_cnt = 0;
   logic        hold = 1'b0;
   logic [7:0]  hold_data = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", {31'd0, m_valid}, 32'd0);
         chk("rst_occ", {30'd0, occ}, 32'd0);
         chk("rst_xfer", {16'd0, xfer_count}, 32'd0);
         chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
         chk("rst_data", {24'd0, m_data}, 32'd0);
         exp_out.delete();
         m_occ  = 0;
         m_infl = 0;
         m_cnt  = 0;
         hold   = 1'b0;
      end else begin
         pop_i = (m_occ != 0 && m_ready) ? 1 : 0;
         chk("occ", {30'd0, occ}, m_occ);
         chk("occ4", {30'd0, occ4}, m_occ);
         chk("valid", {31'd0, m_valid}, (m_occ != 0) ? 32'd1 : 32'd0);
         chk("valid4", {31'd0, valid4}, (m_occ != 0) ? 32'd1 : 32'd0);
         if (m_occ != 0) begin
            chk("data_order", {24'd0, m_data}, exp_out.size() > 0 ? {24'd0, exp_out[0]} : 32'hDEAD);
            chk("data_order4", {24'd0, data4}, exp_out.size() > 0 ? {24'd0, exp_out[0]} : 32'hDEAD);
         end
         if (hold) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data", {24'd0, m_data}, {24'd0, hold_data});
         end
         chk("xfer", {16'd0, xfer_count}, m_cnt & 32'hFFFF);
         chk("xfer4", {28'd0, xfer4}, m_cnt & 32'hF);
         exp_rd = (!fifo_empty && (m_occ + m_infl - pop_i) < 2) ? 1 : 0;
         chk("rd_en", {31'd0, fifo_rd_en}, exp_rd);
         chk("rd_en4", {31'd0, rd_en4}, exp_rd);
         chk("occ_plus_inflight_le2", ((occ + m_infl) <= 2) ? 32'd1 : 32'd0, 32'd1);
         hold      = m_valid && !m_ready;
         hold_data = m_data;
         if (pop_i == 1) begin
            if (exp_out.size() > 0) void'(exp_out.pop_front());
            m_cnt++;
         end
         m_occ  = m_occ + m_infl - pop_i;
         m_infl = exp_rd;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int first;
      int last;
      int pulses;
      int vcnt;
      int sent;
      int cyc;
      logic [7:0] vdata;
      logic [7:0] got[$];

      rst = 1'b1;
      m_ready = 1'b0;
      step();
      step();
      step();
      rst = 1'b0;

      // Single word: rd_en pulse in cycle N, word visible in N+2.
      m_ready = 1'b1;
      wr(8'hA5);
      step();
      pulses = 0; vcnt = 0; first = -1; vdata = 8'h00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (fifo_rd_en) pulses++;
         if (m_valid) begin
            vcnt++;
            if (first < 0) first = i;
            vdata = m_data;
         end
         step();
      end
      chk("single_rd_pulses", pulses, 1);
      chk("single_valid_cycles", vcnt, 1);
      chk("single_latency", first, 2);
      chk("single_data", {24'd0, vdata}, 32'hA5);
      chk("single_xfer", {16'd0, xfer_count}, 1);

      // Full-rate burst.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) wr(8'(i + 1));
      step();
      got.delete(); first = -1; last = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            got.push_back(m_data);
            if (first < 0) first = i;
            last = i;
         end
         step();
      end
      chk("burst_count", got.size(), 8);
      chk("burst_span", last - first, 7);
      for (int k = 0; k < 8; k++) chk("burst_data", k < got.size() ? {24'd0, got[k]} : 32'hDEAD, k + 1);
      chk("burst_xfer", {16'd0, xfer_count}, 8);

      // Backpressure then release.
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(8'(8'h10 + i));
      step();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         step();
      end
      @(negedge clk);
      chk("stall_occ", {30'd0, occ}, 2);
      chk("stall_rd_en", {31'd0, fifo_rd_en}, 0);
      chk("stall_data", {24'd0, m_data}, 32'h10);
      step();
      m_ready = 1'b1;
      got.delete(); first = -1; last = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            got.push_back(m_data);
            if (first < 0) first = i;
            last = i;
         end
         step();
      end
      chk("release_first", first, 0);
      chk("release_span", last - first, 3);
      chk("release_count", got.size(), 4);
      for (int k = 0; k < 4; k++) chk("release_data", k < got.size() ? {24'd0, got[k]} : 32'hDEAD, 32'h10 + k);

      // Reset while the buffer is full and nothing is in flight.
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(8'(8'h20 + i));
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         step();
      end
      @(negedge clk);
      chk("prerst_occ", {30'd0, occ}, 2);
      chk("prerst_xfer", {16'd0, xfer_count}, 4);
      step();
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, m_valid}, 0);
      chk("midrst_occ", {30'd0, occ}, 0);
      chk("midrst_xfer", {16'd0, xfer_count}, 0);
      chk("midrst_rd_en", {31'd0, fifo_rd_en}, 0);
      step();
      step();
      rst = 1'b0;
      m_ready = 1'b1;
      wr(8'h77);
      step();
      vcnt = 0; vdata = 8'h00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_valid) begin
            vcnt++;
            vdata = m_data;
         end
         step();
      end
      chk("resume_valid_cycles", vcnt, 1);
      chk("resume_data", {24'd0, vdata}, 32'h77);
      chk("resume_xfer", {16'd0, xfer_count}, 1);

      // Counter wrap on the 4-bit instance.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 17; i++) wr(8'(8'h40 + i));
      step();
      for (int i = 0; i < 25; i++) step();
      @(negedge clk);
      chk("wrap_xfer4", {28'd0, xfer4}, 1);
      chk("wrap_xfer16", {16'd0, xfer_count}, 17);
      step();

      // Random backpressure over 1000 words.
      do_reset();
      sent = 0;
      cyc  = 0;
      while (m_cnt < 1000 && cyc < 20000) begin
         m_ready = 1'($urandom_range(0, 1));
         if (sent < 1000 && $urandom_range(0, 3) != 0) begin
            wr(8'(sent * 7 + 3));
            sent++;
         end
         step();
         cyc++;
      end
      chk("random_done", m_cnt, 1000);
      chk("random_xfer", {16'd0, xfer_count}, 1000);
      chk("random_xfer4", {28'd0, xfer4}, 1000 % 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
